accu_group: RTL

//  Parametrised grouped accumulator; successor to the fixed 8-bit/8-sample XOR accumulator.

---
 rtl/accu_group_if.sv | 39 +++
 rtl/accu_group.sv | 109 ++++++++++
 2 files changed

// File: rtl/accu_group_if.sv
// Stream bundle for accu_group: sample input (valid_a/ready_a) and result output (valid_b/ready_b).
// The flush signal exists only when ACCU_FLUSH_EN is defined.
interface accu_group_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 11,
  parameter int unsigned CNT_W  = 4
);
  logic [DATA_W-1:0] data_in;
  logic              valid_a;
  logic              ready_a;
  logic              mode;
`ifdef ACCU_FLUSH_EN
  logic              flush;
`endif
  logic              valid_b;
  logic              ready_b;
  logic [OUT_W-1:0]  data_out;
  logic [CNT_W-1:0]  cnt_out;

`ifdef ACCU_FLUSH_EN
  modport master (
    output data_in, valid_a, mode, flush, ready_b,
    input  ready_a, valid_b, data_out, cnt_out
  );
  modport slave (
    input  data_in, valid_a, mode, flush, ready_b,
    output ready_a, valid_b, data_out, cnt_out
  );
`else
  modport master (
    output data_in, valid_a, mode, ready_b,
    input  ready_a, valid_b, data_out, cnt_out
  );
  modport slave (
    input  data_in, valid_a, mode, ready_b,
    output ready_a, valid_b, data_out, cnt_out
  );
`endif
endinterface

// File: rtl/accu_group.sv
// Grouped SUM/XOR accumulator: reduces every GROUP_N accepted samples into one buffered result.
// Define ACCU_FLUSH_EN to add a flush input that closes a partial group early.
module accu_group #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GROUP_N = 8,
  parameter int unsigned OUT_W   = DATA_W + $clog2(GROUP_N),
  parameter int unsigned CNT_W   = $clog2(GROUP_N + 1)
) (
  input logic         clk,
  input logic         rst,
  accu_group_if.slave bus
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(GROUP_N - 1);

  logic [OUT_W-1:0] acc_q, acc_d, acc_next, din_ext;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grp_mode_q, grp_mode_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             slot_free, flush_eff, flush_close, last, accept;

  assign slot_free = !valid_q || bus.ready_b;

`ifdef ACCU_FLUSH_EN
  assign flush_eff   = bus.flush && ((cnt_q != '0) || bus.valid_a);
  // Flush without a sample emits the partial group only once the result slot is free.
  assign flush_close = flush_eff && !bus.valid_a && slot_free;
`else
  assign flush_eff   = 1'b0;
  assign flush_close = 1'b0;
`endif

  assign last        = (cnt_q == LastCnt) || flush_eff;
  assign bus.ready_a = slot_free || !last;
  assign accept      = bus.valid_a && bus.ready_a;

  assign din_ext = OUT_W'(bus.data_in);

  // The first sample of a group seeds acc; later samples use the mode latched with it.
  always_comb begin
    if (cnt_q == '0) begin
      acc_next = din_ext;
    end else if (grp_mode_q) begin
      acc_next = acc_q ^ din_ext;
    end else begin
      acc_next = acc_q + din_ext;
    end
  end

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    grp_mode_d = grp_mode_q;
    valid_d    = valid_q;
    data_d     = data_q;
    cnt_out_d  = cnt_out_q;

    if (valid_q && bus.ready_b) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (cnt_q == '0) begin
        grp_mode_d = bus.mode;
      end
      if (last) begin
        data_d    = acc_next;
        cnt_out_d = cnt_q + CNT_W'(1);
        valid_d   = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (flush_close) begin
      data_d    = acc_q;
      cnt_out_d = cnt_q;
      valid_d   = 1'b1;
      acc_d     = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      grp_mode_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      cnt_out_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      grp_mode_q <= grp_mode_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      cnt_out_q  <= cnt_out_d;
    end
  end

  assign bus.valid_b  = valid_q;
  assign bus.data_out = data_q;
  assign bus.cnt_out  = cnt_out_q;

endmodule
